// File: rtl/core_link_rx.sv
// core_link_rx: receiving end of the 11-bit core link.
// Corrects single-bit errors in the Hamming(7,4) field (bits 10..4), keeps
// the 4-bit IP field (bits 3..0) verbatim, and buffers corrected packets in
// a small FIFO toward the router local input. It also reports each correction
// and counts corrections in a saturating counter.
module core_link_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [10:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_pulse,
    output logic [2:0]               err_syn,
    output logic [CNT_W-1:0]         err_count,
    input  logic                     clr_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Syndrome of a received code field r = {D4,D3,D2,P4,D1,P2,P1}, r[0]=P1.
    function automatic logic [2:0] f_syndrome(input logic [6:0] r);
        logic s0, s1, s2;
        s0 = r[0] ^ r[2] ^ r[4] ^ r[6];
        s1 = r[1] ^ r[2] ^ r[5] ^ r[6];
        s2 = r[3] ^ r[4] ^ r[5] ^ r[6];
        return {s2, s1, s0};
    endfunction

    // A non-zero syndrome names the 1-based position of the bit to flip.
    // Double errors are deliberately miscorrected by the same rule.
    function automatic logic [6:0] f_correct(input logic [6:0] r, input logic [2:0] s);
        logic [6:0] mask;
        mask = '0;
        if (s != 3'd0) begin
            mask = 7'd1 << (s - 3'd1);
        end
        return r ^ mask;
    endfunction

    // Saturating increment of the correction counter.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          r_err_pulse;
    logic [2:0]    r_err_syn;
    logic [CNT_W-1:0] r_err_count;

    logic [2:0]    w_syn;
    logic [6:0]    w_fixed;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_err;

    assign w_syn       = f_syndrome(in_data[10:4]);
    assign w_fixed     = f_correct(in_data[10:4], w_syn);
    // No bypass: a full FIFO refuses input even when the head is being popped.
    assign w_in_ready  = (r_level < LW'(DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_err       = w_push & (w_syn != 3'd0);

    // Storage holds only data; it is not reset, occupancy is tracked by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_fixed, in_data[3:0]};
        end
    end

    // Read/write pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Occupancy: unchanged on simultaneous push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Error report: one-cycle pulse, syndrome held until the next error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_pulse <= 1'b0;
            r_err_syn   <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) r_err_syn <= w_syn;
        end
    end

    // Correction counter: clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (clr_count) begin
            r_err_count <= '0;
        end else if (w_err) begin
            r_err_count <= f_sat_inc(r_err_count);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // Head is forced to zero while empty so stale storage never shows.
    assign out_data  = w_out_valid ? r_mem[r_rd] : 11'd0;
    assign err_pulse = r_err_pulse;
    assign err_syn   = r_err_syn;
    assign err_count = r_err_count;
    assign level     = r_level;

endmodule

// File: tb/tb_core_link_rx.sv
// Directed bench for core_link_rx: clean and corrupted packets, backpressure,
// streaming across pointer wrap, counter saturation/clear, mid-stream reset.
module tb_core_link_rx;

    logic        clk;
    logic        reset;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_pulse;
    logic [2:0]  err_syn;
    logic [7:0]  err_count;
    logic        clr_count;
    logic [2:0]  level;

    logic [10:0] s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [10:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_err_pulse;
    logic [2:0]  s_err_syn;
    logic [1:0]  s_err_count;
    logic        s_clr_count;
    logic [2:0]  s_level;

    int n_total;
    int n_bad;

    core_link_rx #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_pulse(err_pulse), .err_syn(err_syn), .err_count(err_count),
        .clr_count(clr_count), .level(level)
    );

    core_link_rx #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .err_pulse(s_err_pulse), .err_syn(s_err_syn), .err_count(s_err_count),
        .clr_count(s_clr_count), .level(s_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Hamming(7,4) encoder: layout {D4,D3,D2,P4,D1,P2,P1,IP[3:0]}.
    function automatic logic [10:0] enc(input logic [3:0] d, input logic [3:0] ip);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1, ip};
    endfunction

    logic [10:0] pk [5];
    logic [10:0] cw;

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_clr_count = 1'b0;
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_syn", err_syn, 0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b0;
        tick();

        // Clean packet
        in_data = 11'h525; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("clean_out_data", out_data, 11'h525);
        chk("clean_out_valid", out_valid, 1);
        chk("clean_err_pulse", err_pulse, 0);
        chk("clean_err_count", err_count, 0);
        tick();
        chk("clean_drained", level, 0);

        // Single error in each code bit
        in_valid = 1'b1;
        for (int b = 4; b <= 10; b++) begin
            in_data = 11'h525 ^ (11'd1 << b);
            tick();
            chk($sformatf("err_b%0d_data", b), out_data, 11'h525);
            chk($sformatf("err_b%0d_pulse", b), err_pulse, 1);
            chk($sformatf("err_b%0d_syn", b), err_syn, b - 3);
            chk($sformatf("err_b%0d_count", b), err_count, b - 3);
        end
        // IP-bit flip passes through, previous syndrome held
        in_data = 11'h524;
        tick();
        in_valid = 1'b0;
        chk("ip_flip_data", out_data, 11'h524);
        chk("ip_flip_pulse", err_pulse, 0);
        chk("ip_flip_syn_held", err_syn, 7);
        chk("ip_flip_count", err_count, 7);
        tick();
        chk("ip_drained", level, 0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pk[i] = enc(4'(i + 1), 4'(i + 8));
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = pk[i];
            tick();
        end
        chk("bp_level_full", level, 4);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_head", out_data, pk[0]);
        in_data = pk[4];
        tick();
        chk("bp_hold_level", level, 4);
        chk("bp_hold_head", out_data, pk[0]);
        out_ready = 1'b1;
        tick();
        chk("bp_no_bypass_level", level, 3);
        chk("bp_out1", out_data, pk[1]);
        chk("bp_in_ready_free", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_push5_level", level, 3);
        chk("bp_out2", out_data, pk[2]);
        tick();
        chk("bp_out3", out_data, pk[3]);
        tick();
        chk("bp_out4", out_data, pk[4]);
        chk("bp_level1", level, 1);
        tick();
        chk("bp_empty", out_valid, 0);

        // Streaming across pointer wrap
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cw = enc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            in_data = cw;
            tick();
            chk($sformatf("str%0d_data", i), out_data, cw);
            chk($sformatf("str%0d_level", i), level, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drained", level, 0);

        // Saturating counter, CNT_W=2
        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        s_in_data = 11'h425;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("sat%0d_count", k), s_err_count, (k < 3) ? k + 1 : 3);
            chk($sformatf("sat%0d_data", k), s_out_data, 11'h525);
        end
        s_clr_count = 1'b1;
        tick();
        s_clr_count = 1'b0;
        s_in_valid = 1'b0;
        chk("clr_wins_count", s_err_count, 0);
        chk("clr_err_pulse", s_err_pulse, 1);

        // Reset mid-stream with level=3
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = pk[i];
            tick();
        end
        in_valid = 1'b0;
        chk("mid_level3", level, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_err_count", err_count, 0);
        tick();
        reset = 1'b0;
        tick();
        in_data = 11'h525 ^ 11'h040;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_first", out_data, 11'h525);
        chk("post_rst_level", level, 1);
        chk("post_rst_syn", err_syn, 3);
        tick();
        chk("post_rst_drained", level, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
